toggle_sync_scheduler: RTL and testbench
========================================

Name: toggle_sync_scheduler

Overview:
Source-domain scheduler that shares one toggle synchronizer channel between N_REQ event requesters. Each requester's single-cycle pulse is captured as a pending flag. Pending flags are granted round-robin, one at a time. Each grant is issued as one pulse_in-compatible pulse plus a stable requester ID sideband, spaced far enough apart that the destination domain can resolve every toggle. Sits in the clk_a domain directly in front of toggle_sync.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, $clog2(N_REQ), width of sync_id (derived, not overridden)
GAP_CYCLES, 6, idle cycles enforced after each issued pulse (>=1; elaboration error otherwise)
ACK_MODE, 0, 0 = gap only; 1 = after the gap, also wait for ack_in returned from the destination domain

Ports:
clk  in  1  source-domain clock
rst  in  1  synchronous, active-high reset
req_pulse  in  N_REQ  per-requester single-cycle event strobe
ack_in  in  1  single-cycle ack, already synchronized into clk; ignored when ACK_MODE=0
ovf_clr  in  1  clears all overflow flags
sync_pulse  out  1  single-cycle pulse to toggle_sync pulse_in
sync_id  out  ID_W  ID of the most recently issued requester, held until the next issue
pending  out  N_REQ  per-requester pending flag
overflow  out  N_REQ  sticky per-requester lost-event flag
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 sampled at posedge):
  - state=IDLE; pending=0; overflow=0; sync_pulse=0; sync_id=0; gap counter=0; ack_seen=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
- Pending capture:
  - req_pulse[i]=1 sets pending[i] on the next edge.
  - If pending[i] is already 1 and is not being cleared by a grant this edge, the request is dropped and overflow[i] is set.
  - Grant of i and a new req_pulse[i] on the same edge: pending[i] stays 1, no overflow; the old event is issued and the new one is queued.
- Overflow flags:
  - Clear only via ovf_clr or rst.
  - ovf_clr and a new overflow on the same edge: the set wins.
- FSM states: IDLE, ISSUE, GAP, WAIT_ACK.
  - IDLE: if any pending bit is 1, select the winner = first set bit searching last_grant+1, +2, ... with wrap modulo N_REQ. On the same edge:
    - go to ISSUE;
    - sync_id <= winner; last_grant <= winner;
    - clear pending[winner];
    - sync_pulse <= 1.
  - ISSUE: lasts exactly one cycle, with sync_pulse=1. Next edge: sync_pulse <= 0, gap counter <= GAP_CYCLES-1, go to GAP.
  - GAP: counter decrements each cycle. When it reaches 0, go to WAIT_ACK if ACK_MODE=1, otherwise IDLE.
  - WAIT_ACK: exit to IDLE on the first cycle where ack_in=1 or ack_seen=1; clear ack_seen on exit. No timeout; the state persists until an ack.
- ack_seen: in ACK_MODE=1, an ack_in arriving during ISSUE or GAP sets ack_seen, so an early ack is never lost. ack_in in IDLE is ignored.
- Latency and throughput:
  - Request sampled at edge t sets pending at t+1.
  - The earliest issue decision is made in IDLE during cycle t+1, so sync_pulse=1 in cycle t+2.
  - With ACK_MODE=0, consecutive sync_pulse assertions are exactly GAP_CYCLES+2 cycles apart under continuous load.
- sync_pulse is never high on two consecutive cycles. sync_id changes only on the edge that asserts sync_pulse.
- Reset mid-operation: all state is discarded immediately. sync_pulse drops on the next edge and any pending events are lost, with no overflow flagged.

Test Plan:
1. Reset, then req_pulse=4'b0001 once → sync_pulse high for exactly 1 cycle, 2 cycles after the request; sync_id=0; pending[0] clears; busy high for 1+6 cycles.
2. req_pulse=4'b1111 in one cycle, ACK_MODE=0, GAP_CYCLES=6 → 4 pulses 8 cycles apart with sync_id 0,1,2,3; no overflow.
3. Round-robin fairness: after granting 2, hold requesters 0 and 3 pending → next grant is 3, then 0.
4. Pulse req 1 twice while pending[1]=1 and the FSM is busy in GAP → overflow[1]=1 and only one issue for requester 1; ovf_clr clears it. Pulse req 1 on the exact grant edge → pending[1] stays 1, no overflow.
5. ACK_MODE=1: no ack → FSM stays in WAIT_ACK, busy=1. ack_in during GAP → IDLE immediately after the gap expires. ack_in in IDLE → ignored.
6. Assert rst during GAP with pending=4'b0110 → next cycle all outputs are 0, state is IDLE, and the first post-reset grant goes to requester 0 once requested.

Source files
------------

// File: rtl/toggle_sync_scheduler_if.sv
// Request/grant bundle between the event requesters and the scheduler.
// The master side drives request strobes, acks and the overflow clear.
// The slave side (the scheduler) returns the synchronizer pulse, the ID sideband and status.
interface toggle_sync_scheduler_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_pulse;
  logic             ack_in;
  logic             ovf_clr;
  logic             sync_pulse;
  logic [ID_W-1:0]  sync_id;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] overflow;
  logic             busy;

  modport master (
    output req_pulse, ack_in, ovf_clr,
    input  sync_pulse, sync_id, pending, overflow, busy
  );

  modport slave (
    input  req_pulse, ack_in, ovf_clr,
    output sync_pulse, sync_id, pending, overflow, busy
  );
endinterface

// File: rtl/toggle_sync_scheduler.sv
// Shares one toggle synchronizer channel between N_REQ event sources.
// Incoming strobes are latched as pending flags. The flags are granted round-robin,
// and each grant becomes a single-cycle pulse plus a held requester ID.
// Successive grants are spaced so the destination domain resolves every toggle.
module toggle_sync_scheduler #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 6,
  parameter int ACK_MODE   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  toggle_sync_scheduler_if.slave sched
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("toggle_sync_scheduler: N_REQ must be in 2..16");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("toggle_sync_scheduler: GAP_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    WAIT_ACK
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] ovf_q, ovf_d;
  logic             pulse_q, pulse_d;
  logic             ack_seen_q, ack_seen_d;

  logic [ID_W-1:0]  winner;
  logic [N_REQ-1:0] grant_vec;
  logic [N_REQ-1:0] ovf_set;

  // Round-robin pick: first pending flag after the last grant, wrapping at N_REQ.
  // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (pend_q[(int'(last_q) + k) % N_REQ]) begin
        winner = ID_W'((int'(last_q) + k) % N_REQ);
      end
    end
  end

  // Next-state logic: issue, gap countdown and optional ack wait.
  // Also computes the pending and overflow bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    last_d     = last_q;
    pulse_d    = 1'b0;
    ack_seen_d = ack_seen_q;
    grant_vec  = '0;

    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d           = ISSUE;
          id_d              = winner;
          last_d            = winner;
          grant_vec[winner] = 1'b1;
          pulse_d           = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(GAP_CYCLES - 1);
        state_d = GAP;
        if (ACK_MODE != 0 && sched.ack_in) ack_seen_d = 1'b1;
      end
      GAP: begin
        if (ACK_MODE != 0 && sched.ack_in) ack_seen_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = (ACK_MODE != 0) ? WAIT_ACK : IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_ACK: begin
        if (sched.ack_in || ack_seen_q) begin
          state_d    = IDLE;
          ack_seen_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe onto a flag that is not being granted this edge is lost.
    // A strobe onto a flag that is being granted re-queues the event.
    ovf_set = sched.req_pulse & pend_q & ~grant_vec;
    pend_d  = (pend_q & ~grant_vec) | sched.req_pulse;
    ovf_d   = (ovf_q & ~{N_REQ{sched.ovf_clr}}) | ovf_set;
  end

  // State register with synchronous reset; requester 0 wins the first grant.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      id_q       <= '0;
      last_q     <= ID_W'(N_REQ - 1);
      pend_q     <= '0;
      ovf_q      <= '0;
      pulse_q    <= 1'b0;
      ack_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      pulse_q    <= pulse_d;
      ack_seen_q <= ack_seen_d;
    end
  end

  assign sched.sync_pulse = pulse_q;
  assign sched.sync_id    = id_q;
  assign sched.pending    = pend_q;
  assign sched.overflow   = ovf_q;
  assign sched.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_toggle_sync_scheduler.sv
// Directed bench for toggle_sync_scheduler.
// dut0 runs gap-only pacing (ACK_MODE=0) and dut1 runs with ack return (ACK_MODE=1).
// Both use N_REQ=4 and GAP_CYCLES=6.
module tb_toggle_sync_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  toggle_sync_scheduler_if #(.N_REQ(4)) if0 ();
  toggle_sync_scheduler_if #(.N_REQ(4)) if1 ();

  toggle_sync_scheduler #(.N_REQ(4), .GAP_CYCLES(6), .ACK_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .sched(if0)
  );
  toggle_sync_scheduler #(.N_REQ(4), .GAP_CYCLES(6), .ACK_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .sched(if1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next dut0 pulse, then check its ID.
  task automatic wait_pulse0(input string tag, input logic [1:0] exp_id);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!if0.sync_pulse && n < 30);
    check({tag, "_pulse"}, 32'(if0.sync_pulse), 32'd1);
    check({tag, "_id"}, 32'(if0.sync_id), 32'(exp_id));
  endtask

  task automatic wait_idle0(input string tag);
    int n = 0;
    while (if0.busy && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(if0.busy), 32'd0);
  endtask

  initial begin
    int pulse_n;
    int pcyc [4];
    int pid  [4];

    rst = 1'b1;
    if0.req_pulse = '0; if0.ack_in = 1'b0; if0.ovf_clr = 1'b0;
    if1.req_pulse = '0; if1.ack_in = 1'b0; if1.ovf_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset values, then a single request from requester 0.
    check("rst_pulse", 32'(if0.sync_pulse), 32'd0);
    check("rst_id",    32'(if0.sync_id),    32'd0);
    check("rst_pend",  32'(if0.pending),    32'd0);
    check("rst_ovf",   32'(if0.overflow),   32'd0);
    check("rst_busy",  32'(if0.busy),       32'd0);
    if0.req_pulse = 4'b0001;
    tick();
    if0.req_pulse = '0;
    check("t1_pend_set",  32'(if0.pending),    32'h1);
    check("t1_no_pulse",  32'(if0.sync_pulse), 32'd0);
    tick();
    check("t1_pulse",     32'(if0.sync_pulse), 32'd1);
    check("t1_id",        32'(if0.sync_id),    32'd0);
    check("t1_pend_clr",  32'(if0.pending),    32'd0);
    check("t1_busy_iss",  32'(if0.busy),       32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t1_gap_pulse", 32'(if0.sync_pulse), 32'd0);
      check("t1_gap_busy",  32'(if0.busy),       32'd1);
    end
    tick();
    check("t1_idle", 32'(if0.busy), 32'd0);

    // 2: all four request at once after a fresh reset.
    // Expect pulses 8 cycles apart with IDs 0,1,2,3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if0.req_pulse = 4'b1111;
    tick();
    if0.req_pulse = '0;
    check("t2_pend", 32'(if0.pending), 32'hF);
    pulse_n = 0;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (if0.sync_pulse) begin
        if (pulse_n < 4) begin
          pcyc[pulse_n] = c;
          pid[pulse_n]  = int'(if0.sync_id);
        end
        pulse_n++;
      end
    end
    check("t2_count", 32'(pulse_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_id",  32'(pid[i]),  32'(i));
      check("t2_cyc", 32'(pcyc[i]), 32'(1 + 8 * i));
    end
    check("t2_ovf",  32'(if0.overflow), 32'd0);
    check("t2_pend_empty", 32'(if0.pending), 32'd0);

    // 3: grant 2, then hold 0 and 3 pending; the order must be 3 then 0.
    if0.req_pulse = 4'b0100;
    tick();
    if0.req_pulse = '0;
    tick();
    check("t3_pulse2", 32'(if0.sync_pulse), 32'd1);
    check("t3_id2",    32'(if0.sync_id),    32'd2);
    tick();
    if0.req_pulse = 4'b1001;
    tick();
    if0.req_pulse = '0;
    check("t3_pend", 32'(if0.pending), 32'h9);
    wait_pulse0("t3_g3", 2'd3);
    wait_pulse0("t3_g0", 2'd0);
    wait_idle0("t3_idle");

    // 4: requester 0 is granted. During its gap, strobe req 1 three times.
    // The third strobe comes with ovf_clr, and the overflow set must win.
    if0.req_pulse = 4'b0001;
    tick();
    if0.req_pulse = '0;
    tick();
    check("t4_pulse0", 32'(if0.sync_pulse), 32'd1);
    check("t4_id0",    32'(if0.sync_id),    32'd0);
    if0.req_pulse = 4'b0010;
    tick();
    tick();
    check("t4_pend1", 32'(if0.pending),  32'h2);
    check("t4_ovf1",  32'(if0.overflow), 32'h2);
    if0.ovf_clr = 1'b1;
    tick();
    if0.req_pulse = '0;
    if0.ovf_clr   = 1'b0;
    check("t4_set_wins", 32'(if0.overflow), 32'h2);
    wait_pulse0("t4_g1", 2'd1);
    pulse_n = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (if0.sync_pulse) pulse_n++;
    end
    check("t4_single_issue", 32'(pulse_n), 32'd0);
    check("t4_pend_empty",   32'(if0.pending), 32'd0);
    if0.ovf_clr = 1'b1;
    tick();
    if0.ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(if0.overflow), 32'd0);
    // Strobe req 1 again on the edge that grants it: the event re-queues.
    if0.req_pulse = 4'b0010;
    tick();
    tick();
    if0.req_pulse = '0;
    check("t4_ge_pulse", 32'(if0.sync_pulse), 32'd1);
    check("t4_ge_id",    32'(if0.sync_id),    32'd1);
    check("t4_ge_pend",  32'(if0.pending),    32'h2);
    check("t4_ge_ovf",   32'(if0.overflow),   32'd0);
    wait_pulse0("t4_requeued", 2'd1);
    wait_idle0("t4_idle");

    // 5: ACK_MODE=1 on dut1. An ack seen in IDLE is ignored, so the FSM must hold in WAIT_ACK.
    if1.ack_in = 1'b1;
    tick();
    if1.ack_in    = 1'b0;
    if1.req_pulse = 4'b0001;
    tick();
    if1.req_pulse = '0;
    tick();
    check("t5_pulse", 32'(if1.sync_pulse), 32'd1);
    for (int i = 0; i < 7; i++) tick();
    check("t5_wait_busy", 32'(if1.busy), 32'd1);
    for (int i = 0; i < 13; i++) tick();
    check("t5_still_wait", 32'(if1.busy), 32'd1);
    if1.ack_in = 1'b1;
    tick();
    if1.ack_in = 1'b0;
    check("t5_ack_exit", 32'(if1.busy), 32'd0);
    // An early ack during GAP is remembered, and the FSM exits right after the gap.
    if1.req_pulse = 4'b0010;
    tick();
    if1.req_pulse = '0;
    tick();
    check("t5b_pulse", 32'(if1.sync_pulse), 32'd1);
    check("t5b_id",    32'(if1.sync_id),    32'd1);
    tick();
    if1.ack_in = 1'b1;
    tick();
    if1.ack_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t5b_gap_busy", 32'(if1.busy), 32'd1);
    tick();
    tick();
    check("t5b_early_ack", 32'(if1.busy), 32'd0);

    // 6: reset during GAP with requesters 1 and 2 pending.
    // Everything is discarded, and requester 0 has priority again afterwards.
    if0.req_pulse = 4'b0001;
    tick();
    if0.req_pulse = '0;
    tick();
    check("t6_pulse0", 32'(if0.sync_pulse), 32'd1);
    tick();
    if0.req_pulse = 4'b0110;
    tick();
    if0.req_pulse = '0;
    check("t6_pend", 32'(if0.pending), 32'h6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_pulse", 32'(if0.sync_pulse), 32'd0);
    check("t6_id",    32'(if0.sync_id),    32'd0);
    check("t6_pendz", 32'(if0.pending),    32'd0);
    check("t6_ovf",   32'(if0.overflow),   32'd0);
    check("t6_busy",  32'(if0.busy),       32'd0);
    pulse_n = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (if0.sync_pulse) pulse_n++;
    end
    check("t6_lost", 32'(pulse_n), 32'd0);
    if0.req_pulse = 4'b1001;
    tick();
    if0.req_pulse = '0;
    tick();
    check("t6_post_pulse", 32'(if0.sync_pulse), 32'd1);
    check("t6_post_id",    32'(if0.sync_id),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
